machine_d_driver: RTL and testbench

- Serial stimulus generator for the single-bit sequence-detector machines (machine_d family).
- Loads a parallel pattern and shifts it out one bit per CLK on x, MSB first.
- Counts the detector's F responses during the transfer, so one detector can be exercised and scored in hardware without a bench process.
- Drives a 3-bit state code S in the same style as the detector machines.

---
 rtl/machine_d_driver.sv | 97 +++++++++
 tb/tb_machine_d_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/machine_d_driver.sv
`default_nettype none
// ============================================================================
// machine_d_driver: shifts a parallel pattern out MSB-first on x and counts
// the detector's F responses over the transfer.  Rev 1.0
// ============================================================================
module machine_d_driver #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [CW-1:0] len,
  input  logic          F,
  output logic          x,
  output logic          busy,
  output logic          done,
  output logic [2:0]    S,
  output logic [CW-1:0] hits
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b011
  } state_t;

  localparam logic [CW-1:0] C_W = CW'(W);

  state_t        r_state;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_count;
  logic          r_x;
  logic [CW-1:0] r_hits;

  logic [CW-1:0] w_n;
  logic [W-1:0]  w_aligned;

  // Left-align the n active bits so the next bit to send is always the MSB.
  always_comb begin
    w_n       = (len == '0 || len > C_W) ? C_W : len;
    w_aligned = pattern << (C_W - w_n);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
      r_x     <= 1'b0;
      r_hits  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= w_aligned;
            r_count <= w_n;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_hits  <= '0;
          r_x     <= r_shift[W-1];
          r_shift <= r_shift << 1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (F) r_hits <= r_hits + CW'(1);
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_x     <= 1'b0;
            r_state <= DONE;
          end else begin
            r_x     <= r_shift[W-1];
            r_shift <= r_shift << 1;
          end
        end
        DONE: begin
          // F is registered in the detector, so its last response lands here.
          if (F) r_hits <= r_hits + CW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x    = r_x;
  assign busy = (r_state == LOAD) || (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign S    = r_state;
  assign hits = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_machine_d_driver.sv
`default_nettype none
// ============================================================================
// tb_machine_d_driver: randomized and directed checks of machine_d_driver
// against a transfer-level reference model.  Rev 1.0
// ============================================================================
module tb_machine_d_driver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       F = 1'b0;
  logic       x, busy, done;
  logic [2:0] S;
  logic [3:0] hits;

  machine_d_driver #(.W(8), .CW(4)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
    .F(F), .x(x), .busy(busy), .done(done), .S(S), .hits(hits)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: m_t counts cycles since the accepting edge
  // (1 = LOAD, 2..n+1 = SHIFT, n+2 = DONE).
  bit         m_act = 1'b0;
  int         m_t = 0;
  int         m_n = 8;
  int         m_hits = 0;
  logic [7:0] m_pat = '0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_act  = 1'b0;
      m_t    = 0;
      m_hits = 0;
    end else if (m_act) begin
      if (m_t == 1) m_hits = 0;
      if (m_t >= 2 && F) m_hits = m_hits + 1;
      if (m_t == m_n + 2) m_act = 1'b0;
      else m_t = m_t + 1;
    end else if (start) begin
      m_act = 1'b1;
      m_t   = 1;
      m_n   = (len == 0 || len > 8) ? 8 : int'(len);
      m_pat = pattern;
    end
  end

  always @(negedge CLK) begin
    int e_s, e_x, e_busy, e_done;
    e_s = 0; e_x = 0; e_busy = 0; e_done = 0;
    if (m_act) begin
      if (m_t == 1) e_s = 1;
      else if (m_t <= m_n + 1) begin
        e_s = 2;
        e_x = int'(m_pat[m_n - 1 - (m_t - 2)]);
      end else e_s = 3;
      e_busy = (m_t <= m_n + 1) ? 1 : 0;
      e_done = (m_t == m_n + 2) ? 1 : 0;
    end
    chk("S", 32'(S), 32'(e_s));
    chk("x", 32'(x), 32'(e_x));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("hits", 32'(hits), 32'(m_hits));
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] xs;
    int d0, d1, cyc;
    bit found;

    // Reset held for two cycles with start asserted.
    #1 RESET = 1'b1;
    start = 1'b1; pattern = 8'h0B; len = 4'd4; F = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("rst_S", 32'(S), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_hits", 32'(hits), 0);
    end
    RESET = 1'b0;
    step(1);
    chk("rst_release_load", 32'(S), 1);
    start = 1'b0;

    // Basic transfer 0B, len 4.
    xs = '0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      xs = {xs[6:0], x};
    end
    chk("basic_x", 32'(xs[3:0]), 32'h0000000B);
    step(1);
    chk("basic_done", 32'(done), 1);
    step(1);
    chk("basic_idle", 32'(S), 0);
    chk("basic_hits", 32'(hits), 0);

    // Full width via len=0, F tied high.
    pattern = 8'hA5; len = 4'd0; F = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      xs = {xs[6:0], x};
    end
    chk("full_x", 32'(xs), 32'h000000A5);
    step(2);
    chk("full_hits", 32'(hits), 9);

    // start while busy must not disturb the stream.
    pattern = 8'h3C; len = 4'd6; F = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      xs = {xs[6:0], x};
      if (i == 1) begin start = 1'b1; pattern = 8'hFF; end
      if (i == 2) start = 1'b0;
    end
    chk("busy_ign_x", 32'(xs[5:0]), 32'h0000003C);
    step(4);
    chk("busy_ign_idle", 32'(S), 0);

    // Held start: transfers repeat every 5 cycles.
    pattern = 8'h02; len = 4'd2; F = 1'b1; start = 1'b1;
    d0 = -1; d1 = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      step(1);
      if (done) begin
        if (d0 < 0) d0 = cyc;
        else if (d1 < 0) d1 = cyc;
      end
    end
    chk("held_period", 32'(d1 - d0), 5);
    start = 1'b0;
    step(6);

    // Asynchronous reset in the third SHIFT cycle.
    pattern = 8'($urandom); len = 4'd8; F = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (m_act && m_t == 4) found = 1'b1;
    end
    if (!found) chk("async_wait_timeout", 0, 1);
    chk("hits_pre_rst", 32'(hits), 2);
    #1 RESET = 1'b1;
    #1;
    chk("async_S", 32'(S), 0);
    chk("async_x", 32'(x), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_hits", 32'(hits), 0);
    #1 RESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("async_no_done", 32'(done), 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(1);
      start   = ($urandom_range(0, 3) == 0);
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      F       = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    step(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
